// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block: segment patterns (active-low,
// s[6]=A .. s[0]=G), BCD codes for blank/invalid, FSM encoding and a helper.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_HA    = 7'h08;
   localparam logic [6:0] SEG_HB    = 7'h60;
   localparam logic [6:0] SEG_HC    = 7'h31;
   localparam logic [6:0] SEG_HD    = 7'h42;
   localparam logic [6:0] SEG_HE    = 7'h30;
   localparam logic [6:0] SEG_HF    = 7'h38;

   localparam logic [3:0] BCD_BLANK   = 4'hF;
   localparam logic [3:0] BCD_INVALID = 4'hE;

   function automatic logic [2:0] count_low(input logic [3:0] a);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, ~a[i]};
      return n;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to BCD decoder.
// Define SEG7_CAPTURE_HEX_EN to also accept the A-F hex glyphs.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       bad
);

   always_comb begin
      digit = BCD_INVALID;
      bad   = 1'b0;
      case (seg)
         SEG_0:     digit = 4'h0;
         SEG_1:     digit = 4'h1;
         SEG_2:     digit = 4'h2;
         SEG_3:     digit = 4'h3;
         SEG_4:     digit = 4'h4;
         SEG_5:     digit = 4'h5;
         SEG_6:     digit = 4'h6;
         SEG_7:     digit = 4'h7;
         SEG_8:     digit = 4'h8;
         SEG_9:     digit = 4'h9;
         SEG_BLANK: digit = BCD_BLANK;
`ifdef SEG7_CAPTURE_HEX_EN
         SEG_HA:    digit = 4'hA;
         SEG_HB:    digit = 4'hB;
         SEG_HC:    digit = 4'hC;
         SEG_HD:    digit = 4'hD;
         SEG_HE:    digit = 4'hE;
         SEG_HF:    digit = 4'hF;
`endif
         default:   bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed 4-digit 7-segment display back into BCD frames.
// Optional macro SEG7_CAPTURE_HEX_EN enables A-F glyph decoding in seg7_decode.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        fastclk,
   input  logic        rst_n,
   input  logic [3:0]  Ao,
   input  logic [6:0]  s,
   input  logic        Do,
   input  logic        err_clr,
   output logic [15:0] q,
   output logic [3:0]  dp,
   output logic        valid,
   output logic        frame,
   output logic        err
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] ST_MAX = SW'(STABLE_CYCLES);
   localparam logic [SW-1:0] ST_HIT = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT_CYCLES - 1);

   // {Ao, s, Do}, all idle-high
   logic [11:0] sync1, sync2, prev;
   logic [3:0]  ao_s;
   logic [6:0]  s_s;
   logic        do_s;
   logic        change, one_hot, multi, hit, latch, timeout, err_evt;
   logic [2:0]  lows;
   logic [3:0]  sel, mask;
   logic [SW-1:0] st_cnt;
   logic [TW-1:0] to_cnt;
   logic [3:0][3:0] shadow_q;
   logic [3:0]  shadow_dp;
   logic [3:0]  dec_digit;
   logic        dec_bad;
   state_t      state, state_next;

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= {Ao, s, Do};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign ao_s    = sync2[11:8];
   assign s_s     = sync2[7:1];
   assign do_s    = sync2[0];
   assign change  = (sync2 != prev);
   assign lows    = count_low(ao_s);
   assign one_hot = (lows == 3'd1);
   assign multi   = (lows >= 3'd2);
   assign sel     = ~ao_s;

   // Counts unchanged cycles; saturates so each stable interval hits once
   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n)               st_cnt <= '0;
      else if (change)          st_cnt <= '0;
      else if (st_cnt != ST_MAX) st_cnt <= st_cnt + 1'b1;
   end

   assign hit = !change && (st_cnt == ST_HIT);

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      latch      = 1'b0;
      case (state)
         ST_IDLE:   if (one_hot) state_next = ST_SETTLE;
         ST_SETTLE: begin
            if (!one_hot) state_next = ST_IDLE;
            else if (hit) begin
               state_next = ST_HELD;
               latch      = 1'b1;
            end
         end
         ST_HELD:   if (change) state_next = one_hot ? ST_SETTLE : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   seg7_decode u_decode (
      .seg   (s_s),
      .digit (dec_digit),
      .bad   (dec_bad)
   );

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q  <= '0;
         shadow_dp <= '0;
      end else if (latch) begin
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
               shadow_q[i]  <= dec_digit;
               shadow_dp[i] <= ~do_s;
            end
         end
      end
   end

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n)                to_cnt <= '0;
      else if (latch)            to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
   end

   // A latch in the timeout cycle resets the counter and suppresses the timeout
   assign timeout = !latch && (to_cnt == TO_HIT);

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         dp    <= '0;
         valid <= 1'b0;
         frame <= 1'b0;
         mask  <= '0;
      end else begin
         frame <= 1'b0;
         if (mask == 4'hF) begin
            q     <= shadow_q;
            dp    <= shadow_dp;
            frame <= 1'b1;
            valid <= 1'b1;
            mask  <= latch ? sel : 4'h0;
         end else if (latch) begin
            mask <= mask | sel;
         end else if (timeout) begin
            valid <= 1'b0;
            mask  <= '0;
         end
      end
   end

   assign err_evt = (latch && dec_bad) || (hit && multi);

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n)       err <= 1'b0;
      else if (err_evt) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: directed scans push expected frames,
// a monitor pops and compares on every frame pulse.
module tb_seg7_capture;

   localparam int S = 16;
   localparam int T = 5000;

   logic        fastclk = 1'b0;
   logic        rst_n;
   logic [3:0]  Ao;
   logic [6:0]  s;
   logic        Do;
   logic        err_clr;
   logic [15:0] q;
   logic [3:0]  dp;
   logic        valid, frame, err;

   typedef struct {
      logic [15:0] q;
      logic [3:0]  dp;
      logic        err;
   } exp_t;

   exp_t sbq[$];
   exp_t exp_e;
   int   checks = 0;
   int   errors = 0;
   int   frames_seen = 0;
   logic [15:0] last_q;

   seg7_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .fastclk (fastclk),
      .rst_n   (rst_n),
      .Ao      (Ao),
      .s       (s),
      .Do      (Do),
      .err_clr (err_clr),
      .q       (q),
      .dp      (dp),
      .valid   (valid),
      .frame   (frame),
      .err     (err)
   );

   always #5 fastclk = ~fastclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic show(input logic [3:0] a, input logic [6:0] seg, input logic d, input int n);
      Ao = a;
      s  = seg;
      Do = d;
      repeat (n) @(negedge fastclk);
   endtask

   always @(negedge fastclk) begin
      if (rst_n && frame) begin
         frames_seen++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got q=%h expected no frame", q);
         end else begin
            exp_e = sbq.pop_front();
            chk("frame_q", 32'(q), 32'(exp_e.q));
            chk("frame_dp", 32'(dp), 32'(exp_e.dp));
            chk("frame_err", 32'(err), 32'(exp_e.err));
         end
      end
   end

   initial begin
      rst_n = 1'b0; Ao = 4'hF; s = 7'h7F; Do = 1'b1; err_clr = 1'b0;
      repeat (5) @(negedge fastclk);
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_frame", 32'(frame), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge fastclk);

      // "1234" with decimal point on digit2
      sbq.push_back('{q: 16'h1234, dp: 4'b0100, err: 1'b0});
      show(4'hE, 7'h4C, 1'b1, 1000);
      show(4'hD, 7'h06, 1'b1, 1000);
      show(4'hB, 7'h12, 1'b0, 1000);
      show(4'h7, 7'h4F, 1'b1, 1000);
      show(4'hF, 7'h7F, 1'b1, 20);
      chk("scan1234_frames", 32'(frames_seen), 32'd1);
      chk("scan1234_valid", 32'(valid), 32'h1);
      chk("scan1234_err", 32'(err), 32'h0);

      // 10-cycle glitches of digit0 must not latch
      sbq.push_back('{q: 16'h5678, dp: 4'b0000, err: 1'b0});
      repeat (3) begin
         show(4'hE, 7'h04, 1'b1, 10);
         show(4'hF, 7'h7F, 1'b1, 40);
      end
      show(4'h7, 7'h24, 1'b1, 1000);
      show(4'hB, 7'h20, 1'b1, 1000);
      show(4'hD, 7'h0F, 1'b1, 1000);
      show(4'hF, 7'h7F, 1'b1, 20);
      chk("glitch_no_frame", 32'(frames_seen), 32'd1);
      show(4'hE, 7'h00, 1'b1, 1000);
      show(4'hF, 7'h7F, 1'b1, 20);
      chk("scan5678_frames", 32'(frames_seen), 32'd2);

      // two anodes low together
      show(4'b1100, 7'h7F, 1'b1, 25);
      chk("multi_err", 32'(err), 32'h1);
      err_clr = 1'b1;
      @(negedge fastclk);
      err_clr = 1'b0;
      @(negedge fastclk);
      chk("err_clr", 32'(err), 32'h0);
      show(4'hF, 7'h7F, 1'b1, 20);

      // hex glyph on digit0, blank on digit2
`ifdef SEG7_CAPTURE_HEX_EN
      sbq.push_back('{q: 16'h1F0A, dp: 4'b0000, err: 1'b0});
      last_q = 16'h1F0A;
`else
      sbq.push_back('{q: 16'h1F0E, dp: 4'b0000, err: 1'b1});
      last_q = 16'h1F0E;
`endif
      show(4'hE, 7'h08, 1'b1, 1000);
      show(4'hD, 7'h01, 1'b1, 1000);
      show(4'hB, 7'h7F, 1'b1, 1000);
      show(4'h7, 7'h4F, 1'b1, 1000);
      show(4'hF, 7'h7F, 1'b1, 20);
      chk("hex_frames", 32'(frames_seen), 32'd3);
`ifndef SEG7_CAPTURE_HEX_EN
      err_clr = 1'b1;
      @(negedge fastclk);
      err_clr = 1'b0;
      @(negedge fastclk);
      chk("hex_err_clr", 32'(err), 32'h0);
`endif

      // timeout with all anodes off
      chk("pre_timeout_valid", 32'(valid), 32'h1);
      show(4'hF, 7'h7F, 1'b1, T + 100);
      chk("timeout_valid", 32'(valid), 32'h0);
      chk("timeout_q_held", 32'(q), 32'(last_q));

      // reset mid-frame discards the partial capture
      show(4'hE, 7'h12, 1'b1, 1000);
      show(4'hD, 7'h4F, 1'b1, 1000);
      Ao = 4'hF; s = 7'h7F; Do = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge fastclk);
      chk("midrst_q", 32'(q), 32'h0);
      chk("midrst_dp", 32'(dp), 32'h0);
      chk("midrst_valid", 32'(valid), 32'h0);
      chk("midrst_frame", 32'(frame), 32'h0);
      chk("midrst_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      show(4'hF, 7'h7F, 1'b1, 10);
      sbq.push_back('{q: 16'h0912, dp: 4'b0000, err: 1'b0});
      show(4'hB, 7'h04, 1'b1, 1000);
      show(4'h7, 7'h01, 1'b1, 1000);
      show(4'hF, 7'h7F, 1'b1, 20);
      chk("no_partial_frame", 32'(frames_seen), 32'd3);
      show(4'hE, 7'h12, 1'b1, 1000);
      show(4'hD, 7'h4F, 1'b1, 1000);
      show(4'hF, 7'h7F, 1'b1, 20);
      chk("fresh_frames", 32'(frames_seen), 32'd4);
      chk("fresh_valid", 32'(valid), 32'h1);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
